// File: rtl/cube_raster_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cube_raster_pkg
// Description : Datapath op codes, sequencer state encoding and the
//               registered output bundle shared by the raster sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cube_raster_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_FETCH_RGB = 3'd1;
    localparam logic [2:0] OP_FETCH_DIM = 3'd2;
    localparam logic [2:0] OP_FETCH_TMP = 3'd3;
    localparam logic [2:0] OP_ADD       = 3'd4;
    localparam logic [2:0] OP_SHL       = 3'd5;
    localparam logic [2:0] OP_SHR       = 3'd6;
    localparam logic [2:0] OP_SHIFT_OUT = 3'd7;

    // The *_WAIT states are the stalled halves of PIX_RGB / PIX_TMP.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD_DIM  = 4'd1,
        ST_FETCH_DIM = 4'd2,
        ST_RGB_WAIT  = 4'd3,
        ST_RGB       = 4'd4,
        ST_TMP_WAIT  = 4'd5,
        ST_TMP       = 4'd6,
        ST_ADD       = 4'd7,
        ST_PRIME     = 4'd8,
        ST_BIT       = 4'd9,
        ST_LATCH     = 4'd10
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] dp_addr;
        logic       fifo0_en_load;
        logic       clear_add;
        logic       latch_add;
        logic       data_en;
        logic       data_zero;
        logic       latch_shift;
        logic       last_bit;
        logic       one_bit;
        logic       zero_bit;
    } seq_out_t;

    function automatic logic is_pix_gap(input state_t s);
        return (s == ST_RGB_WAIT) || (s == ST_RGB) || (s == ST_TMP_WAIT) ||
               (s == ST_TMP) || (s == ST_ADD) || (s == ST_PRIME);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cube_raster_seq_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : cube_bit_timer
// Description : Per-bit cycle counter with look-ahead one/zero pulse compares
//               and end-of-bit strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module cube_bit_timer #(
    parameter int BIT_CYCLES = 60,
    parameter int T0H_CYCLES = 19,
    parameter int T1H_CYCLES = 38
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_end,
    output logic o_end_next,
    output logic o_one_next,
    output logic o_zero_next
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CYC_W-1:0] C_LAST_CYC = CYC_W'(BIT_CYCLES - 1);

    logic [CYC_W-1:0] r_cyc_q;
    logic [CYC_W-1:0] w_cyc_d;

    // Counter sits at zero whenever the sequencer is outside a bit period,
    // so every bit period starts from cycle 0.
    always_comb begin
        w_cyc_d = '0;
        if (i_run && !o_end) begin
            w_cyc_d = r_cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cyc_q <= '0;
        end else begin
            r_cyc_q <= w_cyc_d;
        end
    end

    assign o_end       = (r_cyc_q == C_LAST_CYC);
    assign o_end_next  = (w_cyc_d == C_LAST_CYC);
    assign o_one_next  = (w_cyc_d < CYC_W'(T1H_CYCLES));
    assign o_zero_next = (w_cyc_d < CYC_W'(T0H_CYCLES));

endmodule
`default_nettype wire

// File: rtl/cube_raster_seq.sv
`default_nettype none
// ============================================================================
// Module      : cube_raster_seq
// Description : Frame sequencer driving every control input of cube_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module cube_raster_seq
    import cube_raster_pkg::*;
#(
    parameter int NUM_PIXELS     = 64,
    parameter int BITS_PER_PIXEL = 24,
    parameter int BIT_CYCLES     = 60,
    parameter int T0H_CYCLES     = 19,
    parameter int T1H_CYCLES     = 38,
    parameter int LATCH_CYCLES   = 2400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fifo0_ready,
    input  logic       fifo1_ready,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic [2:0] dp_addr_o,
    output logic       fifo0_load_o,
    output logic       fifo1_load_o,
    output logic       fifo0_en_load_o,
    output logic       clear_add_o,
    output logic       latch_add_o,
    output logic       data_en_o,
    output logic       data_zero_o,
    output logic       latch_shift_o,
    output logic       last_bit_o,
    output logic       one_bit_o,
    output logic       zero_bit_o
);

    localparam int BIT_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [PIX_W-1:0] C_LAST_PIX = PIX_W'(NUM_PIXELS - 1);
    localparam logic [LAT_W-1:0] C_LAST_LAT = LAT_W'(LATCH_CYCLES - 1);

    state_t           r_state_q, w_state_d;
    logic [BIT_W-1:0] r_bit_q, w_bit_d;
    logic [PIX_W-1:0] r_pix_q, w_pix_d;
    logic [LAT_W-1:0] r_lat_q, w_lat_d;
    logic             r_underrun_q, w_underrun_d;
    seq_out_t         r_out_q, w_out_d;

    logic w_run, w_bit_end, w_end_next, w_one_next, w_zero_next, w_shift_bit;

    assign w_run = (r_state_q == ST_BIT);

    cube_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES),
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES)
    ) u_bit_timer (
        .clk         (clk),
        .reset       (reset),
        .i_run       (w_run),
        .o_end       (w_bit_end),
        .o_end_next  (w_end_next),
        .o_one_next  (w_one_next),
        .o_zero_next (w_zero_next)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_bit_d      = r_bit_q;
        w_pix_d      = r_pix_q;
        w_lat_d      = r_lat_q;
        w_underrun_d = r_underrun_q;
        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_underrun_d = 1'b0;
                    w_pix_d      = '0;
                    w_state_d    = ST_LOAD_DIM;
                end
            end
            ST_LOAD_DIM:              w_state_d = ST_FETCH_DIM;
            ST_FETCH_DIM, ST_RGB_WAIT: w_state_d = fifo0_ready ? ST_RGB : ST_RGB_WAIT;
            ST_RGB, ST_TMP_WAIT:      w_state_d = fifo1_ready ? ST_TMP : ST_TMP_WAIT;
            ST_TMP:                   w_state_d = ST_ADD;
            ST_ADD:                   w_state_d = ST_PRIME;
            ST_PRIME: begin
                w_bit_d   = '0;
                w_state_d = ST_BIT;
            end
            ST_BIT: begin
                if (w_bit_end) begin
                    if (r_bit_q != C_LAST_BIT) begin
                        w_bit_d = r_bit_q + 1'b1;
                    end else if (r_pix_q != C_LAST_PIX) begin
                        w_pix_d   = r_pix_q + 1'b1;
                        w_state_d = fifo0_ready ? ST_RGB : ST_RGB_WAIT;
                    end else begin
                        w_lat_d   = '0;
                        w_state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (r_lat_q == C_LAST_LAT) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_lat_d = r_lat_q + 1'b1;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        if ((w_state_d == ST_RGB_WAIT) || (w_state_d == ST_TMP_WAIT)) begin
            w_underrun_d = 1'b1;
        end

        // Outputs are decoded from the next state so the registered copy
        // lines up with the state it describes.
        w_shift_bit = (w_state_d == ST_BIT) && w_end_next && (w_bit_d != C_LAST_BIT);

        w_out_d               = '0;
        w_out_d.busy          = (w_state_d != ST_IDLE);
        w_out_d.done          = (r_state_q == ST_LATCH) && (w_state_d == ST_IDLE);
        w_out_d.fifo0_en_load = (w_state_d == ST_LOAD_DIM);
        w_out_d.latch_add     = (w_state_d == ST_TMP);
        w_out_d.clear_add     = (w_state_d == ST_ADD);
        w_out_d.latch_shift   = (w_state_d == ST_PRIME) || w_shift_bit;
        w_out_d.data_zero     = is_pix_gap(w_state_d) || (w_state_d == ST_LATCH);
        w_out_d.data_en       = w_out_d.data_zero || (w_state_d == ST_BIT);
        w_out_d.last_bit      = (w_state_d == ST_BIT) && (w_bit_d == C_LAST_BIT);
        w_out_d.one_bit       = (w_state_d == ST_BIT) && w_one_next;
        w_out_d.zero_bit      = (w_state_d == ST_BIT) && w_zero_next;
        case (w_state_d)
            ST_FETCH_DIM: w_out_d.dp_addr = OP_FETCH_DIM;
            ST_RGB:       w_out_d.dp_addr = OP_FETCH_RGB;
            ST_TMP:       w_out_d.dp_addr = OP_FETCH_TMP;
            ST_ADD:       w_out_d.dp_addr = OP_ADD;
            ST_PRIME:     w_out_d.dp_addr = OP_SHIFT_OUT;
            ST_BIT:       w_out_d.dp_addr = w_shift_bit ? OP_SHIFT_OUT : OP_NOP;
            default:      w_out_d.dp_addr = OP_NOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q    <= ST_IDLE;
            r_bit_q      <= '0;
            r_pix_q      <= '0;
            r_lat_q      <= '0;
            r_underrun_q <= 1'b0;
            r_out_q      <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_bit_q      <= w_bit_d;
            r_pix_q      <= w_pix_d;
            r_lat_q      <= w_lat_d;
            r_underrun_q <= w_underrun_d;
            r_out_q      <= w_out_d;
        end
    end

    assign busy            = r_out_q.busy;
    assign done            = r_out_q.done;
    assign underrun        = r_underrun_q;
    assign dp_addr_o       = r_out_q.dp_addr;
    assign fifo0_en_load_o = r_out_q.fifo0_en_load;
    assign clear_add_o     = r_out_q.clear_add;
    assign latch_add_o     = r_out_q.latch_add;
    assign data_en_o       = r_out_q.data_en;
    assign data_zero_o     = r_out_q.data_zero;
    assign latch_shift_o   = r_out_q.latch_shift;
    assign last_bit_o      = r_out_q.last_bit;
    assign one_bit_o       = r_out_q.one_bit;
    assign zero_bit_o      = r_out_q.zero_bit;

    // FIFO write strobes belong to the CPU/DMA side; this sequencer only pops.
    assign fifo0_load_o    = 1'b0;
    assign fifo1_load_o    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_cube_raster_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cube_raster_seq
// Description : Directed self-checking bench for cube_raster_seq (2 pixels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_raster_seq;

    localparam int NP = 2;

    logic       clk = 1'b0;
    logic       reset, start, fifo0_ready, fifo1_ready;
    logic       busy, done, underrun;
    logic [2:0] dp_addr_o;
    logic       fifo0_load_o, fifo1_load_o, fifo0_en_load_o;
    logic       clear_add_o, latch_add_o, data_en_o, data_zero_o;
    logic       latch_shift_o, last_bit_o, one_bit_o, zero_bit_o;

    always #5 clk = ~clk;

    cube_raster_seq #(.NUM_PIXELS(NP)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .fifo0_ready     (fifo0_ready),
        .fifo1_ready     (fifo1_ready),
        .busy            (busy),
        .done            (done),
        .underrun        (underrun),
        .dp_addr_o       (dp_addr_o),
        .fifo0_load_o    (fifo0_load_o),
        .fifo1_load_o    (fifo1_load_o),
        .fifo0_en_load_o (fifo0_en_load_o),
        .clear_add_o     (clear_add_o),
        .latch_add_o     (latch_add_o),
        .data_en_o       (data_en_o),
        .data_zero_o     (data_zero_o),
        .latch_shift_o   (latch_shift_o),
        .last_bit_o      (last_bit_o),
        .one_bit_o       (one_bit_o),
        .zero_bit_o      (zero_bit_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no, busy_cnt, shift_cnt, last_cnt, last_in_gap, done_cnt;
    int g60, g64, gother, zrun, zrun_done, prev_shift;
    bit have_prev;
    int ones, zeros, ens, stall_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        cyc_no = 0; busy_cnt = 0; shift_cnt = 0; last_cnt = 0; last_in_gap = 0;
        done_cnt = 0; g60 = 0; g64 = 0; gother = 0; zrun = 0; zrun_done = -1;
        prev_shift = 0; have_prev = 1'b0;
    endtask

    // Advance one clock and sample outputs on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc_no++;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            zrun_done = zrun;
        end
        if (last_bit_o) begin
            last_cnt++;
            if (data_zero_o) last_in_gap++;
        end
        if (data_en_o && data_zero_o) zrun++;
        else if (data_en_o) zrun = 0;
        if (latch_shift_o) begin
            shift_cnt++;
            if (have_prev) begin
                if (cyc_no - prev_shift == 60)      g60++;
                else if (cyc_no - prev_shift == 64) g64++;
                else                                gother++;
            end
            prev_shift = cyc_no;
            have_prev  = 1'b1;
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 6000; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        chk(tag, done, 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; fifo0_ready = 1'b1; fifo1_ready = 1'b1;
        clr_mon();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_dp", dp_addr_o, 0);
        chk("rst_data_en", data_en_o, 0);
        chk("rst_underrun", underrun, 0);
        reset = 1'b1;
        tick();

        // Frame 1: both FIFOs ready, exact op order and bit waveform.
        clr_mon();
        start = 1'b1; tick(); start = 1'b0;
        chk("load_dim_strobe", fifo0_en_load_o, 1);
        chk("load_dim_busy", busy, 1);
        chk("load_dim_dp", dp_addr_o, 0);
        tick(); chk("fetch_dim_dp", dp_addr_o, 2);
        tick(); chk("rgb_dp", dp_addr_o, 1);
        chk("rgb_zero", {30'd0, data_en_o, data_zero_o}, 3);
        tick(); chk("tmp_dp", dp_addr_o, 3);
        chk("tmp_latch_add", latch_add_o, 1);
        tick(); chk("add_dp", dp_addr_o, 4);
        chk("add_clear_add", clear_add_o, 1);
        tick(); chk("prime_dp", dp_addr_o, 7);
        chk("prime_latch_shift", latch_shift_o, 1);

        ones = 0; zeros = 0; ens = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            ones  += int'(one_bit_o);
            zeros += int'(zero_bit_o);
            ens   += int'(data_en_o);
            if (i == 0)  chk("bit0_last_bit", last_bit_o, 0);
            if (i == 59) chk("bit0_end_dp", dp_addr_o, 7);
        end
        chk("one_bit_high", ones, 38);
        chk("zero_bit_high", zeros, 19);
        chk("data_en_high", ens, 60);

        wait_done("f1_done");
        chk("f1_busy_cycles", busy_cnt, 5290);
        chk("f1_shift_strobes", shift_cnt, 48);
        chk("f1_gap60", g60, 46);
        chk("f1_gap64", g64, 1);
        chk("f1_gap_other", gother, 0);
        chk("f1_last_bit_cycles", last_cnt, 120);
        chk("f1_last_bit_in_gap", last_in_gap, 0);
        chk("f1_latch_low", zrun_done, 2400);
        chk("f1_done_busy", busy, 0);
        tick();
        chk("f1_done_pulse", done, 0);
        chk("f1_underrun", underrun, 0);

        // Frame 2: FIFO1 empty for 10 cycles at pixel 1.
        clr_mon();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (last_bit_o === 1'b1) break;
            tick();
        end
        chk("f2_px0_last_bit", last_bit_o, 1);
        fifo1_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dp_addr_o === 3'd1) break;
            tick();
        end
        chk("f2_px1_rgb", dp_addr_o, 1);
        stall_ok = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (dp_addr_o == 3'd0 && data_en_o && data_zero_o && underrun && !latch_add_o)
                stall_ok++;
        end
        chk("f2_stall_cycles", stall_ok, 10);
        fifo1_ready = 1'b1;
        tick();
        chk("f2_tmp_dp", dp_addr_o, 3);
        chk("f2_tmp_latch_add", latch_add_o, 1);
        wait_done("f2_done");
        chk("f2_busy_cycles", busy_cnt, 5310 - 10);
        tick();
        chk("f2_underrun_sticky", underrun, 1);

        // Frame 3: start pulsed mid-frame is ignored.
        clr_mon();
        start = 1'b1; tick(); start = 1'b0;
        chk("f3_underrun_cleared", underrun, 0);
        repeat (100) tick();
        start = 1'b1; tick(); start = 1'b0;
        wait_done("f3_done");
        chk("f3_busy_cycles", busy_cnt, 5290);
        chk("f3_shift_strobes", shift_cnt, 48);
        chk("f3_latch_low", zrun_done, 2400);

        // Frame 4: reset held low for two cycles during a bit period.
        tick();
        clr_mon();
        start = 1'b1; tick(); start = 1'b0;
        repeat (200) tick();
        chk("f4_in_bit", {30'd0, data_en_o, data_zero_o}, 2);
        reset = 1'b0;
        tick(); tick();
        chk("f4_rst_busy", busy, 0);
        chk("f4_rst_dp", dp_addr_o, 0);
        chk("f4_rst_data_en", data_en_o, 0);
        chk("f4_rst_one_bit", one_bit_o, 0);
        chk("f4_rst_latch_shift", latch_shift_o, 0);
        reset = 1'b1;
        repeat (5) tick();
        chk("f4_no_done", done_cnt, 0);
        chk("f4_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
